// File: rtl/bidi_message_queue_buf_if.sv
// rtl/bidi_message_queue_buf_if.sv - handshake, payload and status signals of the bidirectional message queue buffer
interface bidi_message_queue_buf_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                  ob_wr_valid;
  logic                  ob_wr_ready;
  logic [DATA_WIDTH-1:0] ob_wr_data;
  logic                  ob_rd_valid;
  logic                  ob_rd_ready;
  logic [DATA_WIDTH-1:0] ob_rd_data;
  logic                  ib_wr_valid;
  logic                  ib_wr_ready;
  logic [DATA_WIDTH-1:0] ib_wr_data;
  logic                  ib_rd_valid;
  logic                  ib_rd_ready;
  logic [DATA_WIDTH-1:0] ib_rd_data;
  logic [CW-1:0]         ob_count;
  logic [CW-1:0]         ib_count;
  logic                  ob_almost_full;
  logic                  ib_almost_full;

  // Producer/consumer side: drives valids, payloads and read-readies
  modport master (
    output ob_wr_valid, ob_wr_data, ob_rd_ready,
    output ib_wr_valid, ib_wr_data, ib_rd_ready,
    input  ob_wr_ready, ob_rd_valid, ob_rd_data,
    input  ib_wr_ready, ib_rd_valid, ib_rd_data,
    input  ob_count, ib_count, ob_almost_full, ib_almost_full
  );

  // Buffer side
  modport slave (
    input  ob_wr_valid, ob_wr_data, ob_rd_ready,
    input  ib_wr_valid, ib_wr_data, ib_rd_ready,
    output ob_wr_ready, ob_rd_valid, ob_rd_data,
    output ib_wr_ready, ib_rd_valid, ib_rd_data,
    output ob_count, ib_count, ob_almost_full, ib_almost_full
  );
endinterface

// File: rtl/bidi_message_queue_buf.sv
// rtl/bidi_message_queue_buf.sv - two independent FWFT FIFOs, outbound (index 0) and inbound (index 1)
module bidi_message_queue_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int AF_THRESH  = DEPTH - 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush,
  bidi_message_queue_buf_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic                  wr_valid [2];
  logic                  wr_ready [2];
  logic [DATA_WIDTH-1:0] wr_data  [2];
  logic                  rd_valid [2];
  logic                  rd_ready [2];
  logic [DATA_WIDTH-1:0] rd_data  [2];
  logic                  push     [2];
  logic                  pop      [2];
  logic                  almost_full [2];

  logic [PW-1:0]         wptr_q  [2];
  logic [PW-1:0]         wptr_d  [2];
  logic [PW-1:0]         rptr_q  [2];
  logic [PW-1:0]         rptr_d  [2];
  logic [CW-1:0]         count_q [2];
  logic [CW-1:0]         count_d [2];
  logic [DATA_WIDTH-1:0] mem_q   [2][DEPTH];
  logic [DATA_WIDTH-1:0] mem_d   [2][DEPTH];

  assign wr_valid[0] = bus.ob_wr_valid;
  assign wr_data[0]  = bus.ob_wr_data;
  assign rd_ready[0] = bus.ob_rd_ready;
  assign wr_valid[1] = bus.ib_wr_valid;
  assign wr_data[1]  = bus.ib_wr_data;
  assign rd_ready[1] = bus.ib_rd_ready;

  assign bus.ob_wr_ready    = wr_ready[0];
  assign bus.ob_rd_valid    = rd_valid[0];
  assign bus.ob_rd_data     = rd_data[0];
  assign bus.ob_count       = count_q[0];
  assign bus.ob_almost_full = almost_full[0];
  assign bus.ib_wr_ready    = wr_ready[1];
  assign bus.ib_rd_valid    = rd_valid[1];
  assign bus.ib_rd_data     = rd_data[1];
  assign bus.ib_count       = count_q[1];
  assign bus.ib_almost_full = almost_full[1];

  // Status flags come only from registered count so ready never depends on valid
  always_comb begin
    for (int d = 0; d < 2; d++) begin
      wr_ready[d]    = (count_q[d] != CW'(DEPTH));
      rd_valid[d]    = (count_q[d] != '0);
      rd_data[d]     = rd_valid[d] ? mem_q[d][rptr_q[d]] : '0;
      almost_full[d] = (count_q[d] >= CW'(AF_THRESH));
      push[d]        = wr_valid[d] & wr_ready[d];
      pop[d]         = rd_valid[d] & rd_ready[d];
    end
  end

  // Next pointers, counts and storage; flush discards any same-cycle transfer
  always_comb begin
    mem_d = mem_q;
    for (int d = 0; d < 2; d++) begin
      wptr_d[d]  = wptr_q[d];
      rptr_d[d]  = rptr_q[d];
      count_d[d] = count_q[d];
      if (flush) begin
        wptr_d[d]  = '0;
        rptr_d[d]  = '0;
        count_d[d] = '0;
      end else begin
        if (push[d]) begin
          mem_d[d][wptr_q[d]] = wr_data[d];
          wptr_d[d]           = wptr_q[d] + PW'(1);
        end
        if (pop[d]) begin
          rptr_d[d] = rptr_q[d] + PW'(1);
        end
        count_d[d] = count_q[d] + CW'(push[d]) - CW'(pop[d]);
      end
    end
  end

  // Control state register; reset outranks flush
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int d = 0; d < 2; d++) begin
        wptr_q[d]  <= '0;
        rptr_q[d]  <= '0;
        count_q[d] <= '0;
      end
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Payload storage is never reset
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: tb/tb_bidi_message_queue_buf.sv
// tb/tb_bidi_message_queue_buf.sv - scoreboard bench for bidi_message_queue_buf
module tb_bidi_message_queue_buf;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int AFT   = 3;

  logic clk;
  logic rstn;
  logic flush;
  int   n_checks;
  int   n_fail;

  logic [DW-1:0] obq[$];
  logic [DW-1:0] ibq[$];

  bidi_message_queue_buf_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  bidi_message_queue_buf #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AFT)) u_dut (
    .clk   (clk),
    .rstn  (rstn),
    .flush (flush),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  task automatic idle_inputs();
    flush           = 1'b0;
    bus.ob_wr_valid = 1'b0;
    bus.ob_wr_data  = '0;
    bus.ob_rd_ready = 1'b0;
    bus.ib_wr_valid = 1'b0;
    bus.ib_wr_data  = '0;
    bus.ib_rd_ready = 1'b0;
  endtask

  // Called just after a falling edge with inputs set; scores one rising edge
  task automatic cycle();
    logic ob_push, ob_pop, ib_push, ib_pop;
    #1;
    check("ob_wr_ready", bus.ob_wr_ready, obq.size() != DEPTH);
    check("ib_wr_ready", bus.ib_wr_ready, ibq.size() != DEPTH);
    check("ob_rd_valid", bus.ob_rd_valid, obq.size() != 0);
    check("ib_rd_valid", bus.ib_rd_valid, ibq.size() != 0);
    check("ob_rd_data", bus.ob_rd_data, (obq.size() != 0) ? obq[0] : '0);
    check("ib_rd_data", bus.ib_rd_data, (ibq.size() != 0) ? ibq[0] : '0);
    ob_push = bus.ob_wr_valid && (obq.size() != DEPTH);
    ob_pop  = bus.ob_rd_ready && (obq.size() != 0);
    ib_push = bus.ib_wr_valid && (ibq.size() != DEPTH);
    ib_pop  = bus.ib_rd_ready && (ibq.size() != 0);
    if (!rstn || flush) begin
      obq.delete();
      ibq.delete();
    end else begin
      if (ob_pop)  void'(obq.pop_front());
      if (ob_push) obq.push_back(bus.ob_wr_data);
      if (ib_pop)  void'(ibq.pop_front());
      if (ib_push) ibq.push_back(bus.ib_wr_data);
    end
    @(posedge clk);
    #1;
    check("ob_count", bus.ob_count, obq.size());
    check("ib_count", bus.ib_count, ibq.size());
    check("ob_almost_full", bus.ob_almost_full, obq.size() >= AFT);
    check("ib_almost_full", bus.ib_almost_full, ibq.size() >= AFT);
    @(negedge clk);
  endtask

  task automatic ob_push_one(input logic [DW-1:0] v);
    idle_inputs();
    bus.ob_wr_valid = 1'b1;
    bus.ob_wr_data  = v;
    cycle();
  endtask

  task automatic ib_push_one(input logic [DW-1:0] v);
    idle_inputs();
    bus.ib_wr_valid = 1'b1;
    bus.ib_wr_data  = v;
    cycle();
  endtask

  task automatic drain_all();
    idle_inputs();
    bus.ob_rd_ready = 1'b1;
    bus.ib_rd_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) cycle();
    idle_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rstn     = 1'b0;
    idle_inputs();
    @(negedge clk);
    cycle();
    cycle();
    rstn = 1'b1;
    cycle();
    check("rst_ob_count", bus.ob_count, 0);
    check("rst_ib_count", bus.ib_count, 0);
    check("rst_ob_rd_valid", bus.ob_rd_valid, 0);
    check("rst_ob_rd_data", bus.ob_rd_data, 0);
    check("rst_ob_wr_ready", bus.ob_wr_ready, 1);
    check("rst_ib_wr_ready", bus.ib_wr_ready, 1);
    check("rst_ob_af", bus.ob_almost_full, 0);
    check("rst_ib_af", bus.ib_almost_full, 0);

    // Fill ob, refuse a fifth, drain in order
    ob_push_one(32'h11);
    ob_push_one(32'h22);
    ob_push_one(32'h33);
    check("fill_af_after3", bus.ob_almost_full, 1);
    ob_push_one(32'h44);
    check("fill_ready_after4", bus.ob_wr_ready, 0);
    check("fill_count_after4", bus.ob_count, 4);
    ob_push_one(32'h55);
    check("fill_count_after5th", bus.ob_count, 4);
    drain_all();
    check("fill_drained", bus.ob_rd_valid, 0);

    // Continuous stream across pointer wrap, count holds at 1
    for (int i = 0; i < 16; i++) begin
      idle_inputs();
      bus.ob_wr_valid = 1'b1;
      bus.ob_wr_data  = DW'(i);
      bus.ob_rd_ready = 1'b1;
      cycle();
      check("stream_count", bus.ob_count, 1);
    end
    drain_all();

    // Full with push and pop together: only the pop happens
    for (int i = 1; i <= DEPTH; i++) ob_push_one(DW'(i));
    idle_inputs();
    bus.ob_wr_valid = 1'b1;
    bus.ob_wr_data  = 32'hAA;
    bus.ob_rd_ready = 1'b1;
    cycle();
    check("full_pp_count", bus.ob_count, 3);
    ob_push_one(32'hAA);
    check("full_next_count", bus.ob_count, 4);
    drain_all();

    // Flush with concurrent push and pop
    ib_push_one(32'h101);
    ib_push_one(32'h102);
    ib_push_one(32'h103);
    ob_push_one(32'h201);
    ob_push_one(32'h202);
    idle_inputs();
    flush           = 1'b1;
    bus.ib_wr_valid = 1'b1;
    bus.ib_wr_data  = 32'h1FF;
    bus.ob_rd_ready = 1'b1;
    cycle();
    idle_inputs();
    check("flush_ob_count", bus.ob_count, 0);
    check("flush_ib_count", bus.ib_count, 0);
    check("flush_ob_valid", bus.ob_rd_valid, 0);
    check("flush_ib_valid", bus.ib_rd_valid, 0);
    cycle();

    // Independence: ob held full while ib streams 8 messages
    for (int i = 0; i < DEPTH; i++) ob_push_one(32'hC0 + DW'(i));
    for (int i = 0; i < 8; i++) begin
      idle_inputs();
      bus.ob_wr_valid = 1'b1;
      bus.ob_wr_data  = 32'hDEAD;
      bus.ib_wr_valid = 1'b1;
      bus.ib_wr_data  = $urandom;
      bus.ib_rd_ready = 1'b1;
      cycle();
      check("indep_ob_count", bus.ob_count, 4);
    end
    drain_all();

    // Reset mid-transfer drops everything
    ob_push_one(32'h77);
    ib_push_one(32'h88);
    rstn = 1'b0;
    idle_inputs();
    bus.ob_wr_valid = 1'b1;
    bus.ob_wr_data  = 32'h99;
    cycle();
    rstn = 1'b1;
    idle_inputs();
    check("midrst_ob_count", bus.ob_count, 0);
    check("midrst_ib_count", bus.ib_count, 0);
    cycle();

    check("end_obq_empty", obq.size(), 0);
    check("end_ibq_empty", ibq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bidi_message_queue_buf.md
# bidi_message_queue_buf

Parametrised, buffered successor to the bidirectional message-queue link. Two independent first-word-fall-through FIFOs connect the message-queue side and the client side:
- the outbound FIFO carries data from the queue to the client;
- the inbound FIFO carries data from the client to the queue.

Each direction has its own valid/ready handshake, occupancy count, almost-full flag and a shared synchronous flush. Producer and consumer can therefore run decoupled for up to DEPTH messages per direction.

## Interface
- DATA_WIDTH, 32, message payload width in bits (≥1)
- DEPTH, 4, entries per direction; power of two, ≥2
- AF_THRESH, DEPTH-1, almost-full asserts when count ≥ AF_THRESH (1..DEPTH)
- CW (localparam), $clog2(DEPTH+1), count width
- clk  in  1  sole clock, rising edge
- rstn  in  1  synchronous active-low reset
- flush  in  1  synchronous clear of both FIFOs
- ob_wr_valid  in  1  queue side offers outbound message
- ob_wr_ready  out  1  outbound FIFO can accept
- ob_wr_data  in  DATA_WIDTH  outbound payload
- ob_rd_valid  out  1  outbound message available to client
- ob_rd_ready  in  1  client accepts outbound message
- ob_rd_data  out  DATA_WIDTH  outbound head payload
- ib_wr_valid  in  1  client offers inbound message
- ib_wr_ready  out  1  inbound FIFO can accept
- ib_wr_data  in  DATA_WIDTH  inbound payload
- ib_rd_valid  out  1  inbound message available to queue side
- ib_rd_ready  in  1  queue side accepts inbound message
- ib_rd_data  out  DATA_WIDTH  inbound head payload
- ob_count  out  CW  outbound occupancy 0..DEPTH
- ib_count  out  CW  inbound occupancy 0..DEPTH
- ob_almost_full  out  1  ob_count ≥ AF_THRESH
- ib_almost_full  out  1  ib_count ≥ AF_THRESH

## Operation
- The two directions are identical and independent. Below, "wr", "rd" and "count" apply to either direction.
- Push occurs on a clock edge with wr_valid & wr_ready.
- Pop occurs on a clock edge with rd_valid & rd_ready.
- wr_ready = (count != DEPTH). It is registered-state-derived and never depends combinationally on wr_valid or rd_ready.
- rd_valid = (count != 0). rd_data is the payload at the read pointer when rd_valid=1 and is forced to 0 when rd_valid=0.
- Pointers are log2(DEPTH) bits and wrap naturally at DEPTH-1 → 0. count tracks occupancy explicitly, with range 0..DEPTH.
- Push and pop in the same cycle: count unchanged; write pointer and read pointer both advance.
  - At count=DEPTH, the push is blocked (wr_ready=0); only the pop occurs.
  - At count=0, the pop is impossible (rd_valid=0); only the push occurs.
- Order is preserved strictly FIFO per direction. There is no cross-direction ordering.
- A sender may drop wr_valid without a transfer; no protocol check is made. Data is captured only on a push.
- flush=1 at an edge:
  - both pointers and both counts go to 0;
  - any push or pop in the same cycle is discarded;
  - storage contents are not cleared.
- Storage is not reset. Only pointers, counts and flags are reset.

## Timing
- On an edge with rstn=0:
  - ob_count = ib_count = 0;
  - rd_valid = 0 and rd_data = 0 on both sides;
  - wr_ready = 1 on both sides;
  - almost_full = 0 on both sides (AF_THRESH ≥ 1).
- Reset has priority over flush. Reset mid-transfer drops all in-flight messages with no partial state.
- Latency: a push at edge N gives rd_valid=1 with that data after edge N, so it is consumable at edge N+1. Minimum latency is 1 cycle.
- Throughput: 1 message/cycle per direction in steady state, including at count=DEPTH-1 and count=1.
- After a pop at count=DEPTH, wr_ready rises after that edge. A push the same cycle is still refused.
- count and almost_full update on the same edge as the push or pop that changes them.

## Test plan
- Reset, then idle: ob_count=0, ib_count=0, ob_rd_valid=0, ob_rd_data=0, ob_wr_ready=1, ib_wr_ready=1, both almost_full=0.
- DEPTH=4, AF_THRESH=3: push 0x11, 0x22, 0x33, 0x44 on ob with no pops.
  - ob_almost_full=1 after the third push.
  - ob_wr_ready=0 and ob_count=4 after the fourth push.
  - A fifth push offering 0x55 is refused.
  - Popping returns 0x11, 0x22, 0x33, 0x44, then ob_rd_valid=0.
- Continuous stream of 0x0..0xF with both valid and ready held high: one transfer per cycle, 1-cycle latency, data in order across pointer wrap, ob_count stays at 1.
- Full FIFO with simultaneous push (0xAA) and pop: the head pops, 0xAA is not stored, count=3. The next-cycle push of 0xAA is accepted and count=4.
- Fill ib with 3 messages and ob with 2, then assert flush together with ib_wr_valid and ob_rd_ready: both counts become 0, both rd_valid become 0, and the concurrent push and pop are ignored.
- Independence: ob held full with client ob_rd_ready=0 while ib streams 8 messages, all delivered in order, with the ob state unchanged.
